// File: rtl/div_unit_if.sv
// Divider handshake bundle between the execute stage and div_unit.
interface div_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic               start;
  logic               signed_div;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               annul;
  logic               stall_div;
  logic               ready;
  logic [2*WIDTH-1:0] result;

  // Pipeline / hazard side: issues divides, watches stall and result
  modport master (
    output start,
    output signed_div,
    output a,
    output b,
    output annul,
    input  stall_div,
    input  ready,
    input  result
  );

  // Divider side
  modport slave (
    input  start,
    input  signed_div,
    input  a,
    input  b,
    input  annul,
    output stall_div,
    output ready,
    output result
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider (DIV/DIVU) for the MIPS
// execute stage. Produces {HI=remainder, LO=quotient}, raises stall_div while
// busy and aborts on annul.
// Optional feature: define DIV_EARLY_EXIT_EN to finish in one cycle whenever
// |a| < |b| (nonzero divisor).
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_unit_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned REM_W = WIDTH + 1;
  localparam int unsigned RES_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   count_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic               q_neg_q;
  logic               r_neg_q;
  logic               dvz_q;
  logic [RES_W-1:0]   result_q;
  logic               ready_q;

  logic               stall_c;
  logic               launch_c;
  logic               early_hit_c;
  logic [WIDTH-1:0]   abs_a_c;
  logic [WIDTH-1:0]   abs_b_c;
  logic               q_neg_c;
  logic               r_neg_c;
  logic [REM_W-1:0]   rem_sh_c;
  logic [REM_W-1:0]   diff_c;
  logic               ge_c;
  logic [WIDTH-1:0]   rem_step_c;
  logic [WIDTH-1:0]   quo_step_c;

  // Apply sign correction, or the fixed divide-by-zero pattern
  function automatic logic [RES_W-1:0] fix_result(
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] r,
    input logic             qn,
    input logic             rn,
    input logic             dz,
    input logic [WIDTH-1:0] a_raw
  );
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;
    q_fix = qn ? -q : q;
    r_fix = rn ? -r : r;
    if (dz) begin
      fix_result = {a_raw, {WIDTH{1'b1}}};
    end else begin
      fix_result = {r_fix, q_fix};
    end
  endfunction

  // Operand magnitudes and sign flags; 0x80000000 stays 0x80000000 as unsigned
  always_comb begin
    abs_a_c = bus.a;
    abs_b_c = bus.b;
    if (bus.signed_div && bus.a[WIDTH-1]) begin
      abs_a_c = -bus.a;
    end
    if (bus.signed_div && bus.b[WIDTH-1]) begin
      abs_b_c = -bus.b;
    end
    q_neg_c = bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
    r_neg_c = bus.signed_div & bus.a[WIDTH-1];
  end

`ifdef DIV_EARLY_EXIT_EN
  // Short division: quotient is zero when the dividend is below the divisor
  always_comb begin
    early_hit_c = (abs_b_c != '0) && (abs_a_c < abs_b_c);
  end
`else
  // No shortcut: every division runs all iterations
  always_comb begin
    early_hit_c = 1'b0;
  end
`endif

  // A new division is accepted only in IDLE and never alongside a flush
  always_comb begin
    launch_c = (state_q == S_IDLE) & bus.start & ~bus.annul;
  end

  // One restoring step; bit WIDTH of the 33-bit difference is the borrow,
  // which is clear exactly when the shifted remainder is >= the divisor
  always_comb begin
    rem_sh_c   = {rem_q, dvd_q[WIDTH-1]};
    diff_c     = rem_sh_c - {1'b0, dvs_q};
    ge_c       = ~diff_c[WIDTH];
    rem_step_c = ge_c ? diff_c[WIDTH-1:0] : rem_sh_c[WIDTH-1:0];
    quo_step_c = {dvd_q[WIDTH-2:0], ge_c};
  end

  // FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; annul returns to IDLE from any state
  always_comb begin
    state_d = state_q;
    if (bus.annul) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_d = early_hit_c ? S_DONE : S_BUSY;
          end
        end
        S_BUSY: begin
          if (count_q == CNT_LAST) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // FSM output logic: stall is combinational so the pipeline freezes in cycle 0
  always_comb begin
    stall_c = 1'b0;
    if (!bus.annul) begin
      stall_c = ((state_q == S_IDLE) & bus.start) | (state_q == S_BUSY);
    end
  end

  // Datapath: operand capture, iteration, and result/ready registration
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count_q  <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      a_raw_q  <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dvz_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      if (launch_c) begin
        count_q <= '0;
        rem_q   <= '0;
        dvd_q   <= abs_a_c;
        dvs_q   <= abs_b_c;
        a_raw_q <= bus.a;
        q_neg_q <= q_neg_c;
        r_neg_q <= r_neg_c;
        dvz_q   <= (bus.b == '0);
        if (early_hit_c) begin
          result_q <= fix_result('0, abs_a_c, q_neg_c, r_neg_c, 1'b0, bus.a);
          ready_q  <= 1'b1;
        end
      end else if ((state_q == S_BUSY) && !bus.annul) begin
        rem_q   <= rem_step_c;
        dvd_q   <= quo_step_c;
        count_q <= count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          result_q <= fix_result(quo_step_c, rem_step_c, q_neg_q, r_neg_q,
                                 dvz_q, a_raw_q);
          ready_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.stall_div = stall_c;
  assign bus.ready     = ready_q;
  assign bus.result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul / back-to-back / reset
// sequences. Latency expectations follow DIV_EARLY_EXIT_EN.
module tb_div_unit;

`ifdef DIV_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int FULL_LAT = 33;

  logic clk;
  logic resetn;
  int   total;
  int   bad;
  logic [63:0] last_exp;

  div_unit_if #(.WIDTH(32)) dif ();

  div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          early;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Issue one divide at the next negedge and watch a bounded window
  task automatic run_div(input string nm, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [63:0] exp, input int lat);
    int stalls;
    int readies;
    int first;
    logic [63:0] got;
    stalls = 0; readies = 0; first = -1; got = '0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (c == 0) begin
        dif.start = 1'b1; dif.signed_div = sgn; dif.a = a; dif.b = b;
      end else begin
        dif.start = 1'b0;
      end
      #1;
      if (dif.stall_div) stalls++;
      if (dif.ready) begin
        readies++;
        if (first < 0) begin
          first = c;
          got = dif.result;
        end
      end
    end
    chk({nm, "_result"}, got, exp);
    chk({nm, "_ready_cycle"}, 64'(first), 64'(lat));
    chk({nm, "_stall_cycles"}, 64'(stalls), 64'(lat));
    chk({nm, "_ready_count"}, 64'(readies), 64'd1);
    last_exp = exp;
  endtask

  initial begin
    int lat;
    int readies;
    int stalls;
    logic [63:0] r33;
    logic [63:0] r67;
    total = 0; bad = 0; last_exp = '0;
    r33 = '0; r67 = '0;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'd2,          32'hFFFFFFFF,   32'hFFFFFFFD,   1'b0};
    vecs[2]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h0,          32'h80000000,   1'b0};
    vecs[3]  = '{1'b0, 32'd5,          32'd0,          32'd5,          32'hFFFFFFFF,   1'b0};
    vecs[4]  = '{1'b0, 32'd3,          32'd10,         32'd3,          32'd0,          1'b1};
    vecs[5]  = '{1'b1, 32'hFFFFFFFB,   32'd0,          32'hFFFFFFFB,   32'hFFFFFFFF,   1'b0};
    vecs[6]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[7]  = '{1'b0, 32'hFFFFFFFF,   32'h10,         32'hF,          32'h0FFFFFFF,   1'b0};
    vecs[8]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'd1,          32'hFFFFFFFD,   1'b0};
    vecs[9]  = '{1'b1, 32'hFFFFFFFD,   32'd10,         32'hFFFFFFFD,   32'd0,          1'b1};
    vecs[10] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b1};
    vecs[11] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[12] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'hFFFFFFFE,   32'd14,         1'b0};
    vecs[13] = '{1'b1, 32'd0,          32'd5,          32'd0,          32'd0,          1'b1};

    // Reset state
    resetn = 1'b0;
    dif.start = 1'b0; dif.signed_div = 1'b0; dif.a = '0; dif.b = '0; dif.annul = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall_idle", 64'(dif.stall_div), 64'd0);
    chk("rst_ready", 64'(dif.ready), 64'd0);
    chk("rst_result", dif.result, 64'd0);
    dif.start = 1'b1;
    #1;
    chk("rst_stall_start", 64'(dif.stall_div), 64'd1);
    dif.start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;

    // Vector table
    foreach (vecs[i]) begin
      lat = (vecs[i].early && EE) ? 1 : FULL_LAT;
      run_div($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
              {vecs[i].hi, vecs[i].lo}, lat);
    end

    // Annul in BUSY cycle 10
    readies = 0;
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd1000; dif.b = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      dif.start = 1'b0;
      dif.annul = (c == 10);
      #1;
      if (dif.ready) readies++;
      if (c == 10) chk("annul_stall_low", 64'(dif.stall_div), 64'd0);
      if (c == 11) chk("annul_idle_next", 64'(dif.stall_div), 64'd0);
    end
    chk("annul_no_ready", 64'(readies), 64'd0);
    chk("annul_result_kept", dif.result, last_exp);
    run_div("after_annul", 1'b0, 32'd1000, 32'd3, {32'd1, 32'd333}, FULL_LAT);

    // annul together with start in IDLE: nothing launches
    readies = 0;
    @(negedge clk);
    dif.start = 1'b1; dif.annul = 1'b1; dif.a = 32'd50; dif.b = 32'd4;
    #1;
    chk("annul_start_stall", 64'(dif.stall_div), 64'd0);
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      dif.start = 1'b0; dif.annul = 1'b0;
      #1;
      if (dif.ready) readies++;
      if (c == 0) chk("annul_start_not_busy", 64'(dif.stall_div), 64'd0);
    end
    chk("annul_start_no_ready", 64'(readies), 64'd0);

    // Back-to-back: start held through the first DONE for the second divide
    readies = 0; stalls = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      dif.start = (c <= 67);
      dif.signed_div = 1'b0;
      if (c < 33) begin
        dif.a = 32'd100; dif.b = 32'd7;
      end else begin
        dif.a = 32'd1000; dif.b = 32'd3;
      end
      #1;
      if (dif.stall_div) stalls++;
      if (dif.ready) begin
        readies++;
        if (c == 33) r33 = dif.result;
        if (c == 67) r67 = dif.result;
      end
      if (c == 33) chk("b2b_done_stall_low", 64'(dif.stall_div), 64'd0);
      if (c == 34) chk("b2b_second_start_stall", 64'(dif.stall_div), 64'd1);
    end
    chk("b2b_ready_count", 64'(readies), 64'd2);
    chk("b2b_stall_cycles", 64'(stalls), 64'd66);
    chk("b2b_first_result", r33, {32'd2, 32'd14});
    chk("b2b_second_result", r67, {32'd1, 32'd333});

    // Reset asserted mid-operation
    @(negedge clk);
    dif.start = 1'b1; dif.signed_div = 1'b0; dif.a = 32'd100; dif.b = 32'd7;
    repeat (5) begin
      @(negedge clk);
      dif.start = 1'b0;
    end
    resetn = 1'b0;
    #1;
    chk("midrst_stall", 64'(dif.stall_div), 64'd0);
    chk("midrst_ready", 64'(dif.ready), 64'd0);
    chk("midrst_result", dif.result, 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    run_div("post_reset", 1'b1, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, FULL_LAT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative radix-2 divider for the execute stage of the MIPS pipeline. It computes 32-bit signed or unsigned DIV/DIVU into a 64-bit {HI, LO} result. It drives `stall_div` to the hazard unit, which freezes IF/ID/EX while a division is in flight. It is the producer side of the divider-stall handshake and aborts cleanly when the hazard unit flushes EX on an exception.

## Interface

Parameters:
- `WIDTH`, default 32: operand width. Only 32 is supported; it sets internal counter and datapath sizing.

Ports:
- `clk`  in  1  pipeline clock.
- `resetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  a DIV/DIVU instruction occupies EX this cycle (already gated by valid).
- `signed_div`  in  1  1 = DIV (signed), 0 = DIVU. Sampled with `start`.
- `a`  in  32  dividend (rs, post-forwarding). Stable while `stall_div` is high.
- `b`  in  32  divisor (rt, post-forwarding).
- `annul`  in  1  flush of EX, driven by the exception flush. Aborts any operation.
- `stall_div`  out  1  to hazard `stall_divE`. Combinational.
- `ready`  out  1  result valid. One-cycle pulse.
- `result`  out  64  {remainder → HI [63:32], quotient → LO [31:0]}. Held until the next start.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: on `start & ~annul`, latch `|a|` and `|b|` (absolute values only if `signed_div`). Also latch sign flags q_neg = a[31]^b[31] and r_neg = a[31], both gated by `signed_div`. Clear the partial remainder, load count = 0, and go to BUSY.
- BUSY: one restoring step per cycle. Shift {rem, dvd} left by 1. If rem ≥ |b|, subtract and set the quotient bit. After the 32nd step (count = 31), go to DONE.
- DONE: register the sign-corrected result. Negate the quotient if q_neg and the remainder if r_neg. Pulse `ready`, then go to IDLE unconditionally; `start` is ignored in DONE.
- `stall_div` = ~annul & ((IDLE & start) | BUSY). It is low in DONE, so the pipeline advances on the DONE cycle.
- `annul` in any state: the next state is IDLE, `ready` is not pulsed, and `result` keeps its old value.
- Divide by zero is not trapped and runs the full latency. The result is forced to LO = 0xFFFFFFFF and HI = a (raw dividend), irrespective of `signed_div`.
- Overflow case 0x80000000 / 0xFFFFFFFF signed gives LO = 0x80000000 and HI = 0 (wrap, no trap).
- Arithmetic: the remainder datapath is 33 bits, to hold the compare/subtract carry. Absolute value of 0x80000000 is 0x80000000 treated as unsigned.

## Timing

- Reset: state = IDLE, `stall_div` = 0 (unless `start`), `ready` = 0, `result` = 0, count = 0.
- Cycle 0: `start` seen in IDLE, `stall_div` = 1, operands latched.
- Cycles 1–32: BUSY, `stall_div` = 1.
- Cycle 33: DONE, `stall_div` = 0, `ready` = 1, `result` valid from the start of this cycle (registered at the end of cycle 32).
- Total: 33 stall cycles, latency 33 cycles.
- Back-to-back divides: the second `start` is seen in the cycle after DONE, in IDLE. No gap is required by the pipeline.
- Reset asserted mid-operation: immediate return to reset values.
- `annul` and `start` asserted together in IDLE: `annul` wins, so there is no stall and no start.

## Configuration

- `DIV_EARLY_EXIT_EN` defined:
  - In IDLE, if `|a| < |b|` (unsigned compare, divisor nonzero), skip BUSY and go directly to DONE with quotient 0 and remainder `|a|`, sign-corrected.
  - Stall is 1 cycle (cycle 0 only); `ready` is in cycle 1.
- `DIV_EARLY_EXIT_EN` undefined: every division takes the full 33 cycles. No comparator is present in IDLE.

## Test plan

- DIVU a=100, b=7 → `stall_div` high for 33 cycles, `ready` in cycle 33, result = {HI=2, LO=14}.
- DIV a=−7 (0xFFFFFFF9), b=2 → HI = 0xFFFFFFFF (−1), LO = 0xFFFFFFFD (−3). DIV 0x80000000 / 0xFFFFFFFF → HI=0, LO=0x80000000.
- DIVU a=5, b=0 → full latency, HI = 5, LO = 0xFFFFFFFF.
- `annul` in BUSY cycle 10 → `stall_div` low that cycle, IDLE next, no `ready`, previous result unchanged. A new `start` next cycle runs the full 33 cycles correctly.
- Two divides back-to-back (start held across DONE for the second instruction): exactly one `ready` per divide, and the DONE cycle does not restart.
- With `DIV_EARLY_EXIT_EN`: DIVU 3/10 → 1 stall cycle, `ready` in cycle 1, HI=3, LO=0. Without it: the same stimulus takes 33 cycles with an identical result.
